max_idx_10: RTL and testbench
=============================

# max_idx_10

Sequential arg-max unit that reports which of ten signed values is largest. It sits at the output of the network processor. When the program reaches its final instruction, it captures the ten output-layer scores from the first word of data memory. It then produces the 4-bit class index and a sticky `done` flag. The flag stays set until the block is reset.

## Interface

Parameters:
- `WIDTH`, default 8: bit width of each input value, interpreted as two's-complement signed.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high. Forces idle state, `idx`=0, `done`=0.
- `inputs`  in  10×`WIDTH` (unpacked array `[10]`, element 0 = index 0): signed candidate values.
- `start`  in  1: request to begin a search. Level-sensitive, sampled only in IDLE, may be held high.
- `idx`  out  4: index (0–9) of the maximum value. Registered.
- `done`  out  1: result valid. Registered and sticky.

## Operation

- The block has three states: IDLE, SCAN and DONE. Reset enters IDLE.
- IDLE, `start`=1 at a rising edge:
  - Latch all ten `inputs` into an internal register file.
  - Set best_val = element 0, best_idx = 0, ptr = 1.
  - Go to SCAN.
- IDLE, `start`=0: no state change.
- SCAN, each edge, comparing element[ptr] against best_val:
  - If element[ptr] > best_val (strict, signed), set best_val = element[ptr] and best_idx = ptr.
  - If ptr = 9, drive `idx` from the final best index including this comparison, set `done` = 1, and go to DONE.
  - Otherwise increment ptr.
- DONE: `idx` and `done` hold. `start` is ignored. The only exit is `reset`.
- `start` during SCAN is ignored. Changes on `inputs` after the capture edge are ignored.
- Ties resolve to the lowest index, because the comparison is strictly greater.
- Comparison is fully signed over `WIDTH` bits, e.g. 8'h80 = -128 is less than 8'hFF = -1.
- `idx` keeps its previous value (0 after reset) until the edge that sets `done`. It never shows intermediate best indices.
- No arithmetic widening is needed: compare only, 4-bit pointer.

## Timing

- Reset values: `idx` = 4'd0, `done` = 0, state = IDLE, ptr = 0. Outputs clear asynchronously the moment `reset` rises, with no clock required.
- If `reset` and `start` are both high, reset wins. The first capture happens at the first edge after `reset` deasserts on which `start`=1.
- Latency, with E0 the edge that samples `start`=1 in IDLE:
  - Edges E1–E8 compare elements 1–8.
  - E9 compares element 9 and sets `done`=1 and the final `idx`.
  - Both outputs are valid immediately after E9, i.e. 10 edges including the capture edge.
- Throughput: one search per reset. A new search requires `reset`, then `start`.
- Reset mid-SCAN aborts the search. `done` stays 0 and `idx` returns to 0. No partial result is ever exposed.

## Test plan

- Ascending: inputs {0,1,…,9}, pulse `start` one cycle → `done`=0 through E8; after E9, `done`=1 and `idx`=9.
- All equal: all ten = -5 → `idx`=0 after E9 (lowest index wins).
- Signed: inputs {-128,-1,-1,-1,127,-1,-1,-1,-1,-128} (8'h80 at 0 and 9) → `idx`=4. Also {-128, then all -100} → `idx`=1.
- Tie: value 50 at indices 2 and 7, all others 10 → `idx`=2.
- Capture and hold:
  - Hold `start` high continuously with values favouring index 3.
  - Rewrite `inputs` to favour index 8 one cycle after E0.
  - Expect `idx`=3 and `done`=1 after E9, both unchanged for 20 further cycles with `start` still high.
- Async reset:
  - Start a search and assert `reset` between E4 and E5 without a clock edge → `done`=0 and `idx`=0 immediately.
  - Release `reset`, start again with max at index 6 → `idx`=6 ten edges after the new capture edge.

Source files
------------

// File: rtl/max_idx_10.sv
// Sequential arg-max over ten signed values: capture on start, scan one element
// per clock, then hold a sticky result until reset.
module max_idx_10 #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] inputs [10],
  input  logic                    start,
  output logic [3:0]              idx,
  output logic                    done,
  output logic [1:0]              o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_vals [10];
  logic signed [WIDTH-1:0] r_best_val;
  logic [3:0]              r_best_idx;
  logic [3:0]              r_ptr;

  logic signed [WIDTH-1:0] w_cur;
  logic                    w_gt;
  logic [3:0]              w_new_idx;

  assign o_state = r_state;

  always_comb begin
    w_cur = r_vals[0];
    for (int i = 1; i < 10; i++) begin
      if (r_ptr == 4'(i)) w_cur = r_vals[i];
    end
  end

  // Strictly greater keeps the lowest index on ties.
  assign w_gt      = (w_cur > r_best_val);
  assign w_new_idx = w_gt ? r_ptr : r_best_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_best_val <= '0;
      r_best_idx <= 4'd0;
      r_ptr      <= 4'd0;
      idx        <= 4'd0;
      done       <= 1'b0;
      for (int i = 0; i < 10; i++) r_vals[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < 10; i++) r_vals[i] <= inputs[i];
            r_best_val <= inputs[0];
            r_best_idx <= 4'd0;
            r_ptr      <= 4'd1;
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_gt) r_best_val <= w_cur;
          r_best_idx <= w_new_idx;
          if (r_ptr == 4'd9) begin
            // idx only ever sees the final answer, never an intermediate best.
            idx     <= w_new_idx;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ptr <= r_ptr + 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max_idx_10.sv
// Directed bench for max_idx_10: driver pushes expected indices, a negedge
// monitor pops and compares whenever done rises.
module tb_max_idx_10;

  typedef logic signed [7:0] vec_t [10];

  logic              clk;
  logic              reset;
  logic signed [7:0] inputs [10];
  logic              start;
  logic [3:0]        idx;
  logic              done;
  logic [1:0]        o_state;

  logic [3:0] exp_q[$];
  int         checks;
  int         errors;
  logic       prev_done;

  max_idx_10 #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .inputs  (inputs),
    .start   (start),
    .idx     (idx),
    .done    (done),
    .o_state (o_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares the result on every rising edge of done.
  always @(negedge clk) begin
    if (done === 1'b1 && prev_done !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: done rose with idx %0d but nothing expected", idx);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (idx !== e) begin
          errors++;
          $display("FAIL sb_idx: got %0d expected %0d at %0t", idx, e, $time);
        end
      end
    end
    prev_done = done;
  end

  // Driver tasks
  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("rst_done", {7'd0, done}, 8'd0);
    check("rst_idx", {4'd0, idx}, 8'd0);
    check("rst_state", {6'd0, o_state}, 8'd0);
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  task automatic set_inputs(input vec_t v);
    for (int i = 0; i < 10; i++) inputs[i] = v[i];
  endtask

  // Issues start (one-cycle pulse), checks done stays low through E8 and is
  // set with the right idx right after E9.
  task automatic run_search(input string name, input vec_t v, input logic [3:0] exp);
    @(posedge clk); #2;
    set_inputs(v);
    start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;            // E0
    start = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL %s_early_done: done=%b at edge E%0d", name, done, e);
      end
    end
    checks++;
    @(posedge clk); #1;            // E9
    check({name, "_done"}, {7'd0, done}, 8'd1);
    check({name, "_idx"}, {4'd0, idx}, {4'd0, exp});
  endtask

  vec_t v;

  initial begin
    checks    = 0;
    errors    = 0;
    prev_done = 1'b0;
    reset     = 1'b1;
    start     = 1'b1;
    for (int i = 0; i < 10; i++) inputs[i] = 8'sd0;
    #1;
    check("por_done", {7'd0, done}, 8'd0);
    check("por_idx", {4'd0, idx}, 8'd0);
    // start high under reset must not capture
    @(posedge clk); #1;
    check("rst_wins_state", {6'd0, o_state}, 8'd0);
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;

    v = '{8'sd0, 8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8, 8'sd9};
    run_search("ascend", v, 4'd9);
    do_reset();

    for (int i = 0; i < 10; i++) v[i] = -8'sd5;
    run_search("all_eq", v, 4'd0);
    do_reset();

    v = '{-8'sd128, -8'sd1, -8'sd1, -8'sd1, 8'sd127, -8'sd1, -8'sd1, -8'sd1, -8'sd1, -8'sd128};
    run_search("signed_a", v, 4'd4);
    do_reset();

    v[0] = -8'sd128;
    for (int i = 1; i < 10; i++) v[i] = -8'sd100;
    run_search("signed_b", v, 4'd1);
    do_reset();

    v = '{8'sd10, 8'sd10, 8'sd50, 8'sd10, 8'sd10, 8'sd10, 8'sd10, 8'sd50, 8'sd10, 8'sd10};
    run_search("tie", v, 4'd2);
    do_reset();

    // Capture and hold: start stays high, inputs rewritten after E0.
    v = '{8'sd1, 8'sd2, 8'sd3, 8'sd90, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8, 8'sd9};
    @(posedge clk); #2;
    set_inputs(v);
    start = 1'b1;
    exp_q.push_back(4'd3);
    @(posedge clk); #2;            // E0
    for (int i = 0; i < 10; i++) inputs[i] = 8'sd0;
    inputs[8] = 8'sd120;
    repeat (9) @(posedge clk);     // E1..E9
    #1;
    check("hold_done", {7'd0, done}, 8'd1);
    check("hold_idx", {4'd0, idx}, 8'd3);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done !== 1'b1 || idx !== 4'd3) begin
        checks++;
        errors++;
        $display("FAIL hold_cycle%0d: done=%b idx=%0d required done=1 idx=3", c, done, idx);
      end
    end
    checks++;
    start = 1'b0;
    do_reset();

    // Async reset mid-scan, between E4 and E5.
    v = '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd70};
    @(posedge clk); #2;
    set_inputs(v);
    start = 1'b1;
    @(posedge clk); #2;            // E0
    start = 1'b0;
    repeat (4) @(posedge clk);     // E1..E4
    #3;
    reset = 1'b1;
    #1;
    check("abort_done", {7'd0, done}, 8'd0);
    check("abort_idx", {4'd0, idx}, 8'd0);
    check("abort_state", {6'd0, o_state}, 8'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_result", {7'd0, done}, 8'd0);
    check("abort_idle", {6'd0, o_state}, 8'd0);

    v = '{8'sd3, -8'sd7, 8'sd20, 8'sd0, 8'sd19, -8'sd128, 8'sd33, 8'sd32, 8'sd1, 8'sd33};
    run_search("restart", v, 4'd6);

    repeat (3) @(posedge clk);
    check("sb_drained", exp_q.size(), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
